hilo_md_ctrl: RTL
=================

# hilo_md_ctrl

Multiply/divide sequencer that owns all writes to the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU requests from the execute stage and computes a 64-bit result: multiply in one cycle, divide by a 32-iteration restoring algorithm. Holds the pipeline with a stall output while busy, then issues a single write-enable pulse with the HI and LO values.

## Interface
- No parameters; data width fixed at 32 (`RegBus`).
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-low
- `start_i`  in  1  request valid; sampled only in IDLE
- `op_i`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `opdata1_i`  in  32  multiplicand / dividend (rs)
- `opdata2_i`  in  32  multiplier / divisor (rt)
- `annul_i`  in  1  cancel in-flight operation (exception flush)
- `stall_o`  out  1  hold pipeline; combinational
- `done_o`  out  1  one-cycle completion pulse
- `we_o`  out  1  HI/LO write enable, equal to `done_o`
- `hi_o`  out  32  HI result: product[63:32] or remainder
- `lo_o`  out  32  LO result: product[31:0] or quotient

## Operation
- States: IDLE, MUL, DIV_ON, END.
- IDLE, `start_i`=1, mul op → MUL; div op with `opdata2_i`≠0 → DIV_ON; div op with `opdata2_i`=0 → END.
- `start_i`=0 → stay in IDLE.
- Operands are latched at start. Signed ops take magnitudes, and the result sign is fixed at END.
- MUL:
  - Registers the full 64-bit product (signed for MULT, unsigned for MULTU).
  - Goes to END next cycle.
- DIV_ON:
  - 6-bit counter runs 0..31, one quotient bit per cycle.
  - 33-bit partial remainder; subtract when non-negative.
  - Goes to END after iteration 31.
- Sign fix:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero: LO=0xFFFFFFFF, HI=dividend (defined, no exception).
- END:
  - `done_o`=`we_o`=1 for one cycle, `hi_o`/`lo_o` valid.
  - Returns to IDLE, so a new start is accepted the cycle after END.
- `hi_o`/`lo_o` hold their last result until the next END. They are not cleared on return to IDLE.
- `annul_i`=1 in MUL or DIV_ON:
  - Next state IDLE, no write.
  - Results unchanged.
- `annul_i` in END does not suppress the write; the write has already committed.
- `start_i` outside IDLE is ignored.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE, counter 0, `done_o`=`we_o`=0, `hi_o`=`lo_o`=0. `stall_o`=0 unless `start_i` is high.
- Reset overrides everything, including mid-divide; no write occurs.
- `stall_o`:
  - 1 when (IDLE & `start_i`), or MUL, or DIV_ON.
  - 0 in END and in IDLE without start.
  - `annul_i` forces `stall_o`=0 in the same cycle.
- Latency, counting the start cycle as T0:
  - Multiply: MUL T1, END T2 (`done_o` at T2).
  - Divide: DIV_ON T1..T32, END T33.
  - Divide by zero: END at T1.
- Back-to-back: the earliest next start is the cycle after END (IDLE), with no bubble beyond that.

## Configuration
- `HILO_DIV_EN`
- Defined: DIV/DIVU behave as above, including the DIV_ON state and iterative datapath.
- Undefined:
  - Divider logic and DIV_ON are not built.
  - DIV/DIVU go IDLE→END in one cycle and write HI=0, LO=0.
  - Multiply behaviour is unchanged.

## Test plan
- MULT: opdata1=0xFFFFFFFF (-1), opdata2=2 → `done_o` at T2, HI=0xFFFFFFFF, LO=0xFFFFFFFE; stall high at T0–T1.
- MULTU: opdata1=0xFFFFFFFF, opdata2=2 → HI=0x00000001, LO=0xFFFFFFFE.
- DIVU 100/7 → `done_o` at T33, LO=0x0000000E, HI=0x00000002. Then DIV 7/-2 → LO=0xFFFFFFFD, HI=0x00000001. Then DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIV 5/0 → `done_o` at T1, LO=0xFFFFFFFF, HI=0x00000005.
- DIVU 100/7 with `annul_i` at T10 → IDLE at T11, no `we_o`, HI/LO keep prior values. A start at T11 is accepted.
- `rst`=0 at T5 of a divide → all outputs 0 next cycle, no `we_o`. `start_i` while in DIV_ON is ignored.

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multiply/divide sequencer that owns every HI/LO write.
// MULT/MULTU finish in one MUL cycle; DIV/DIVU use a 32-step restoring
// divider on operand magnitudes, with the result sign applied on entry to END.
// Optional feature macro: HILO_DIV_EN. When it is undefined, the divider
// and the DIV_ON state are not built, and DIV/DIVU write HI=0 and LO=0.
module hilo_md_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
`ifdef HILO_DIV_EN
        DIV_ON = 2'd2,
`endif
        END    = 2'd3
    } state_t;

    state_t      state;

    // Operand magnitudes captured at start. During a divide, op_a also
    // serves as the dividend shift register and collects quotient bits.
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        neg_res;

    logic        is_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod_mag;
    logic [63:0] prod_res;

`ifdef HILO_DIV_EN
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic        neg_rem;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
`endif

    // Compute operand magnitudes at the request and the signed or unsigned product from the latched magnitudes
    always_comb begin
        is_signed = ~op_i[0];
        a_mag     = (is_signed && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        b_mag     = (is_signed && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        prod_mag  = {32'd0, op_a} * {32'd0, op_b};
        prod_res  = neg_res ? (~prod_mag + 64'd1) : prod_mag;
    end

`ifdef HILO_DIV_EN
    // Perform one restoring-division step: shift in the next dividend bit and keep the difference when it is non-negative
    always_comb begin
        shifted  = {rem, op_a[31]};
        trial    = shifted - {1'b0, op_b};
        rem_next = trial[32] ? shifted[31:0] : trial[31:0];
        quo_next = {op_a[30:0], ~trial[32]};
    end
`endif

    // Hold the pipeline for an accepted request and while the operation is in flight, unless a flush is in progress
    always_comb begin
        stall_o = 1'b0;
        if (!annul_i) begin
            case (state)
                IDLE:    stall_o = start_i;
                MUL:     stall_o = 1'b1;
`ifdef HILO_DIV_EN
                DIV_ON:  stall_o = 1'b1;
`endif
                default: stall_o = 1'b0;
            endcase
        end
    end

    assign we_o = done_o;

    // Sequencer FSM: accept requests in IDLE, run MUL or DIV_ON, and commit HI/LO with a one-cycle done pulse in END
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            done_o  <= 1'b0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            neg_res <= 1'b0;
`ifdef HILO_DIV_EN
            cnt     <= 6'd0;
            rem     <= 32'd0;
            neg_rem <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        op_a    <= a_mag;
                        op_b    <= b_mag;
                        neg_res <= is_signed & (opdata1_i[31] ^ opdata2_i[31]);
                        if (!op_i[1]) begin
                            state <= MUL;
                        end else begin
`ifdef HILO_DIV_EN
                            if (opdata2_i == 32'd0) begin
                                hi_o   <= opdata1_i;
                                lo_o   <= 32'hFFFF_FFFF;
                                done_o <= 1'b1;
                                state  <= END;
                            end else begin
                                cnt     <= 6'd0;
                                rem     <= 32'd0;
                                neg_rem <= is_signed & opdata1_i[31];
                                state   <= DIV_ON;
                            end
`else
                            hi_o   <= 32'd0;
                            lo_o   <= 32'd0;
                            done_o <= 1'b1;
                            state  <= END;
`endif
                        end
                    end
                end
                MUL: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        hi_o   <= prod_res[63:32];
                        lo_o   <= prod_res[31:0];
                        done_o <= 1'b1;
                        state  <= END;
                    end
                end
`ifdef HILO_DIV_EN
                DIV_ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        rem  <= rem_next;
                        op_a <= quo_next;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            hi_o   <= neg_rem ? (~rem_next + 32'd1) : rem_next;
                            lo_o   <= neg_res ? (~quo_next + 32'd1) : quo_next;
                            done_o <= 1'b1;
                            state  <= END;
                        end
                    end
                end
`endif
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
